// File: rtl/ula_issue_stage.sv
// Operand/issue stage feeding the 16-bit registered ULA: register bank, 3-state issue FSM, writeback and flags.
// Optional immediate operand on alu_b is enabled by defining ULA_ISSUE_IMM_EN.
module ula_issue_stage #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
`ifdef ULA_ISSUE_IMM_EN
    input  logic              in_use_imm,
    input  logic [WIDTH-1:0]  in_imm,
`endif
    input  logic              hw_en,
    input  logic [REG_AW-1:0] hw_addr,
    input  logic [WIDTH-1:0]  hw_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_overflow,
    input  logic              alu_slt,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              flag_zero,
    output logic              flag_overflow,
    output logic              err_illegal
);

    localparam int unsigned NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  bank [NREG];
    logic [REG_AW-1:0] rd_q;
    logic [2:0]        op_q;

    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  res;
    logic              illegal;
    logic              ovf;
    logic              wb_we;

    assign dbg_data = bank[dbg_addr];

    always_comb begin
        b_sel = bank[in_rt];
`ifdef ULA_ISSUE_IMM_EN
        if (in_use_imm) b_sel = in_imm;
`endif
    end

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        case (op_q)
            3'b000, 3'b001, 3'b010, 3'b011: res = alu_result;
            3'b100:                         res = {{(WIDTH-1){1'b0}}, alu_slt};
            default:                        illegal = 1'b1;
        endcase
        ovf   = (op_q == 3'b000 || op_q == 3'b001) && alu_overflow;
        wb_we = (state == CAPTURE) && !illegal && (rd_q != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ctrl      <= '0;
            rd_q          <= '0;
            op_q          <= '0;
            wb_valid      <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            flag_zero     <= 1'b0;
            flag_overflow <= 1'b0;
            err_illegal   <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            wb_valid    <= 1'b0;
            err_illegal <= 1'b0;
            // Host writes to r0 are dropped; a writeback to the same entry on this edge takes priority.
            if (hw_en && hw_addr != '0 && !(wb_we && hw_addr == rd_q))
                bank[hw_addr] <= hw_data;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a    <= bank[in_rs];
                        alu_b    <= b_sel;
                        alu_ctrl <= in_op;
                        rd_q     <= in_rd;
                        op_q     <= in_op;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    if (wb_we) bank[rd_q] <= res;
                    wb_valid      <= 1'b1;
                    wb_addr       <= rd_q;
                    wb_data       <= res;
                    flag_zero     <= (res == '0);
                    flag_overflow <= ovf;
                    err_illegal   <= illegal;
                    in_ready      <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_issue_stage.sv
// Self-checking bench for ula_issue_stage: registered ULA model, behavioural reference bank, directed + random stimulus.
module tb_ula_issue_stage;
    localparam int W  = 16;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd, in_rs, in_rt;
`ifdef ULA_ISSUE_IMM_EN
    logic          in_use_imm;
    logic [W-1:0]  in_imm;
`endif
    logic          hw_en;
    logic [AW-1:0] hw_addr;
    logic [W-1:0]  hw_data;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;
    logic [W-1:0]  alu_a, alu_b;
    logic [2:0]    alu_ctrl;
    logic [W-1:0]  alu_result;
    logic          alu_overflow, alu_slt;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          flag_zero, flag_overflow, err_illegal;

    always #10 clock = ~clock;

    ula_issue_stage #(.WIDTH(W), .REG_AW(AW)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
`ifdef ULA_ISSUE_IMM_EN
        .in_use_imm(in_use_imm), .in_imm(in_imm),
`endif
        .hw_en(hw_en), .hw_addr(hw_addr), .hw_data(hw_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_slt(alu_slt),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_zero(flag_zero), .flag_overflow(flag_overflow), .err_illegal(err_illegal)
    );

    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        if (op == 3'd0) begin
            s = a + b;
            return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else if (op == 3'd1) begin
            s = a - b;
            return (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        return 1'b0;
    endfunction

    // Registered ULA stand-in; non-arithmetic overflow and slt/illegal Result carry junk the stage must ignore.
    always_ff @(posedge clock) begin
        alu_result   <= (alu_ctrl <= 3'd3) ? ref_res(alu_ctrl, alu_a, alu_b) : (alu_a ^ ~alu_b);
        alu_overflow <= (alu_ctrl <= 3'd1) ? ref_ovf(alu_ctrl, alu_a, alu_b) : alu_a[0];
        alu_slt      <= $signed(alu_a) < $signed(alu_b);
    end

    int tests  = 0;
    int failed = 0;

    logic [W-1:0]  mbank [1<<AW];
    int            cnt;
    logic          m_acc;
    logic [AW-1:0] p_rd;
    logic [W-1:0]  p_data;
    logic          p_ovf, p_ill;
    logic          e_wb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one edge: update the reference from the inputs seen at that edge, then compare.
    task automatic step();
        logic          do_wb;
        logic [W-1:0]  b;
        @(posedge clock);
        m_acc = 1'b0;
        do_wb = 1'b0;
        e_wb  = 1'b0;
        if (!reset_n) begin
            for (int i = 0; i < (1 << AW); i++) mbank[i] = '0;
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    do_wb = 1'b1;
                    e_wb  = 1'b1;
                end
            end else if (in_valid) begin
                b = mbank[in_rt];
`ifdef ULA_ISSUE_IMM_EN
                if (in_use_imm) b = in_imm;
`endif
                p_rd   = in_rd;
                p_ill  = in_op > 3'd4;
                p_data = ref_res(in_op, mbank[in_rs], b);
                p_ovf  = ref_ovf(in_op, mbank[in_rs], b);
                cnt    = 2;
                m_acc  = 1'b1;
            end
            if (hw_en && hw_addr != '0 && !(do_wb && !p_ill && p_rd == hw_addr))
                mbank[hw_addr] = hw_data;
            if (do_wb && !p_ill && p_rd != '0) mbank[p_rd] = p_data;
        end
        #1;
        chk("in_ready", 32'(in_ready), 32'(cnt == 0));
        chk("wb_valid", 32'(wb_valid), 32'(e_wb));
        chk("err_illegal", 32'(err_illegal), 32'(e_wb && p_ill));
        if (e_wb) begin
            chk("wb_addr", 32'(wb_addr), 32'(p_rd));
            chk("wb_data", 32'(wb_data), 32'(p_data));
            chk("flag_zero", 32'(flag_zero), 32'(p_data == '0));
            chk("flag_overflow", 32'(flag_overflow), 32'(p_ovf));
        end
        chk("dbg_data", 32'(dbg_data), 32'(mbank[dbg_addr]));
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        hw_en = 1'b1; hw_addr = a; hw_data = d;
        step();
        hw_en = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, output logic [W-1:0] d, output logic z,
                         output logic o, output logic e);
        logic got;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = m_acc;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'(0), 32'(1));
        got = 1'b0;
        d = '0; z = 1'b0; o = 1'b0; e = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (wb_valid) begin
                got = 1'b1;
                d = wb_data; z = flag_zero; o = flag_overflow; e = err_illegal;
            end
        end
        if (!got) chk("wb_timeout", 32'(0), 32'(1));
    endtask

    task automatic dbg_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    logic [W-1:0] d, rv;
    logic         z, o, e;
    int           wbs, last_wb, gap_bad;
    logic [2:0]    b2b_op [4];
    logic [AW-1:0] b2b_rd [4];
    logic [AW-1:0] b2b_rs [4];
    logic [AW-1:0] b2b_rt [4];

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
        hw_en = 1'b0; hw_addr = '0; hw_data = '0; dbg_addr = '0;
`ifdef ULA_ISSUE_IMM_EN
        in_use_imm = 1'b0; in_imm = '0;
`endif
        cnt = 0; p_rd = '0; p_data = '0; p_ovf = 1'b0; p_ill = 1'b0;

        // 1. reset
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_wb_valid", 32'(wb_valid), 32'(0));
        for (int i = 0; i < (1 << AW); i++) begin
            dbg_read(AW'(i), rv);
            chk("rst_bank", 32'(rv), 32'(0));
        end
        reset_n = 1'b1;

        // 2. add with signed overflow
        host_write(3'd1, 16'h7FFF);
        host_write(3'd2, 16'h0001);
        do_op(3'd0, 3'd3, 3'd1, 3'd2, d, z, o, e);
        chk("add_data", 32'(d), 32'h8000);
        chk("add_ovf", 32'(o), 32'(1));
        chk("add_zero", 32'(z), 32'(0));
        dbg_read(3'd3, rv);
        chk("add_r3", 32'(rv), 32'h8000);

        // 3. sub / slt
        do_op(3'd1, 3'd4, 3'd2, 3'd2, d, z, o, e);
        chk("sub_data", 32'(d), 32'h0000);
        chk("sub_zero", 32'(z), 32'(1));
        do_op(3'd4, 3'd5, 3'd2, 3'd1, d, z, o, e);
        chk("slt_true", 32'(d), 32'h0001);
        do_op(3'd4, 3'd6, 3'd1, 3'd2, d, z, o, e);
        chk("slt_false", 32'(d), 32'h0000);
        chk("slt_false_zero", 32'(z), 32'(1));

`ifdef ULA_ISSUE_IMM_EN
        in_use_imm = 1'b1; in_imm = 16'h0005;
        do_op(3'd0, 3'd7, 3'd1, 3'd2, d, z, o, e);
        in_use_imm = 1'b0;
        chk("imm_add", 32'(d), 32'h8004);
`endif

        // 4. back-to-back, including an or into r0
        b2b_op = '{3'd0, 3'd1, 3'd3, 3'd2};
        b2b_rd = '{3'd7, 3'd6, 3'd0, 3'd5};
        b2b_rs = '{3'd1, 3'd3, 3'd2, 3'd4};
        b2b_rt = '{3'd2, 3'd2, 3'd1, 3'd1};
        wbs = 0; last_wb = -1; gap_bad = 0;
        begin
            int idx;
            idx = 0;
            in_valid = 1'b1;
            in_op = b2b_op[0]; in_rd = b2b_rd[0]; in_rs = b2b_rs[0]; in_rt = b2b_rt[0];
            for (int c = 0; c < 16; c++) begin
                step();
                if (m_acc) begin
                    idx++;
                    if (idx < 4) begin
                        in_op = b2b_op[idx]; in_rd = b2b_rd[idx]; in_rs = b2b_rs[idx]; in_rt = b2b_rt[idx];
                    end else in_valid = 1'b0;
                end
                if (wb_valid) begin
                    if (last_wb >= 0 && c - last_wb != 3) gap_bad++;
                    last_wb = c;
                    wbs++;
                end
            end
            in_valid = 1'b0;
        end
        chk("b2b_wb_count", 32'(wbs), 32'(4));
        chk("b2b_wb_gap", 32'(gap_bad), 32'(0));
        dbg_read(3'd0, rv);
        chk("r0_zero", 32'(rv), 32'(0));

        // 5. illegal op leaves rd alone; host write loses to writeback on the same edge
        do_op(3'd6, 3'd3, 3'd1, 3'd2, d, z, o, e);
        chk("ill_err", 32'(e), 32'(1));
        chk("ill_zero", 32'(z), 32'(1));
        chk("ill_ovf", 32'(o), 32'(0));
        dbg_read(3'd3, rv);
        chk("ill_r3_kept", 32'(rv), 32'h8000);
        in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd3; in_rs = 3'd1; in_rt = 3'd1;
        step();
        chk("coll_accept", 32'(m_acc), 32'(1));
        in_valid = 1'b0;
        step();
        hw_en = 1'b1; hw_addr = 3'd3; hw_data = 16'h1234;
        step();
        hw_en = 1'b0;
        chk("coll_wb", 32'(wb_valid), 32'(1));
        dbg_read(3'd3, rv);
        chk("coll_r3", 32'(rv), 32'hFFFE);

        // 6. reset while in ISSUE drops the instruction
        in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd2; in_rs = 3'd1; in_rt = 3'd1;
        step();
        chk("midrst_accept", 32'(m_acc), 32'(1));
        in_valid = 1'b0;
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        wbs = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (wb_valid) wbs++;
        end
        chk("midrst_no_wb", 32'(wbs), 32'(0));
        for (int i = 0; i < (1 << AW); i++) begin
            dbg_read(AW'(i), rv);
            chk("midrst_bank", 32'(rv), 32'(0));
        end

        // random traffic against the reference
        for (int c = 0; c < 600; c++) begin
            in_valid = $urandom_range(0, 2) != 0;
            in_op    = 3'($urandom_range(0, 7));
            in_rd    = AW'($urandom_range(0, 7));
            in_rs    = AW'($urandom_range(0, 7));
            in_rt    = AW'($urandom_range(0, 7));
`ifdef ULA_ISSUE_IMM_EN
            in_use_imm = $urandom_range(0, 3) == 0;
            in_imm     = W'($urandom);
`endif
            hw_en    = $urandom_range(0, 2) == 0;
            hw_addr  = AW'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       hw_data = 16'h0000;
                1:       hw_data = 16'h7FFF;
                2:       hw_data = 16'h8000;
                3:       hw_data = 16'hFFFF;
                default: hw_data = W'($urandom);
            endcase
            dbg_addr = AW'($urandom_range(0, 7));
            reset_n  = $urandom_range(0, 99) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
